id_stage_pipe: RTL and testbench
================================

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/immediate width, legal values 32 or 64.
REQ-002 SHALL have parameter NREGS, default 32, meaning architectural register count, legal values 16 or 32.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning synchronous, active-low reset.
REQ-005 SHALL have ports in_valid  input  1, in_ready  output  1, instruction  input  32, meaning the upstream instruction handshake.
REQ-006 SHALL have ports wb_en  input  1, wb_addr  input  5, wb_data  input  XLEN, meaning the writeback port.
REQ-007 SHALL have port flush  input  1  meaning discard the held instruction.
REQ-008 SHALL have ports out_valid  output  1 and out_ready  input  1, meaning the downstream handshake.
REQ-009 SHALL have outputs rs1_data, rs2_data, imm_data (XLEN each), rd (5), opcode (7) and illegal (1), all registered.

Function
REQ-010 SHALL contain NREGS x XLEN registers, written on the clk edge when wb_en=1, wb_addr!=0 and wb_addr<NREGS; x0 SHALL always read 0.
REQ-011 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-012 SHALL capture on in_valid && in_ready: decode fields, read registers, and set out_valid=1; latency 1 cycle from capture to out_valid.
REQ-013 SHALL clear out_valid when out_ready=1 and no new capture occurs in the same cycle; a simultaneous capture SHALL keep out_valid=1 with the new contents (full throughput).
REQ-014 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-015 SHALL on flush=1 clear out_valid next cycle and block capture that cycle; flush SHALL have priority over capture, and the register file write SHALL still occur.
REQ-016 SHALL form imm_data by opcode: I/load/JALR sign-extended [31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; J {[31],[19:12],[20],[30:21],0}; LUI/AUIPC {[31:12],12'b0}; all sign-extended to XLEN; any other opcode gives 0.
REQ-017 SHALL set illegal=1 when the opcode is outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111}, when rs1, rs2 or rd >= NREGS, or when instruction[1:0]!=2'b11.
REQ-018 SHALL, when illegal=1, still present fields but force rs1_data=rs2_data=0.
REQ-019 SHALL output rd=instruction[11:7] and opcode=instruction[6:0] as captured.

Reset
REQ-020 SHALL on clk edge with rst=0 clear out_valid, all NREGS registers and all data outputs to 0; in_ready SHALL be 1 in the cycle after reset release.
REQ-021 SHALL treat reset mid-handshake as discard: a held instruction is lost, and any wb_en in the reset cycle is ignored.

Configuration
REQ-022 SHALL implement macro ID_STAGE_BYPASS_EN: when defined, a capture-cycle write with wb_addr==rs (nonzero) SHALL deliver wb_data as the operand, and a write matching the rs of a held (stalled) instruction SHALL update that held operand.
REQ-023 SHALL, without ID_STAGE_BYPASS_EN, deliver the pre-write register value on a same-cycle collision and never modify held operands.

Verification
REQ-024 SHALL verify reset: rst=0 for 2 cycles -> out_valid=0, every register reads 0, in_ready=1 after release.
REQ-025 SHALL verify throughput: back-to-back addi x1,x0,-1 (0xFFF00093) with out_ready=1 -> imm_data=0xFFFFFFFF (XLEN=32), out_valid high every cycle, 1-cycle latency.
REQ-026 SHALL verify a stall: out_ready=0 for 3 cycles -> in_ready=0, outputs unchanged; wb x2=0x55 during the stall with rs1=x2 -> rs1_data=0x55 with BYPASS_EN, old value without.
REQ-027 SHALL verify collision: capture rs1=x5 while wb_en, wb_addr=5, wb_data=0xA5 -> rs1_data=0xA5 with BYPASS_EN, 0 without; wb to x0 -> reads 0.
REQ-028 SHALL verify illegality: NREGS=16 with rs2=x20 -> illegal=1 and rs2_data=0; opcode 0x7F -> illegal=1 and imm_data=0.
REQ-029 SHALL verify flush: flush=1 together with in_valid=1 -> out_valid=0 next cycle, no capture, and a concurrent writeback is committed.

Source files
------------

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// IdStagePipe (module id_stage_pipe)
//
// Instruction-decode pipeline stage with an integrated register file.
// It accepts one 32-bit RISC-V style instruction per cycle over a
// valid/ready handshake. For each accepted instruction it decodes the
// fields, builds the immediate, flags illegal encodings and reads both
// source operands. The results are held in a single output register slice
// that is drained by a downstream valid/ready handshake.
//
// Parameters
//   XLEN   operand / immediate width (32 or 64)
//   NREGS  architectural register count (16 or 32)
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous, active-low reset
//   in_valid     upstream instruction valid
//   in_ready     upstream ready (combinational: !out_valid || out_ready)
//   instruction  32-bit instruction word
//   wb_en        writeback enable
//   wb_addr      writeback register index
//   wb_data      writeback value
//   flush        discard the held instruction and refuse capture this cycle
//   out_valid    downstream valid
//   out_ready    downstream ready
//   rs1_data     registered source operand 1 (zero when illegal)
//   rs2_data     registered source operand 2 (zero when illegal)
//   imm_data     registered sign-extended immediate
//   rd           registered destination index (instruction[11:7])
//   opcode       registered opcode (instruction[6:0])
//   illegal      registered illegal-instruction flag
//
// Optional feature
//   ID_STAGE_BYPASS_EN  when defined, a writeback that hits a source
//   register being captured forwards wb_data into the operand, and a
//   writeback that hits a source of the held (stalled) instruction
//   refreshes that held operand. When undefined, a same-cycle collision
//   returns the pre-write register value and held operands never change.
// ---------------------------------------------------------------------------
module id_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm_data,
    output logic [4:0]      rd,
    output logic [6:0]      opcode,
    output logic            illegal
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U
    } immFmt_t;

    logic [XLEN-1:0] r_regs [NREGS];

    logic            r_outValid;
    logic [XLEN-1:0] r_rs1Data;
    logic [XLEN-1:0] r_rs2Data;
    logic [XLEN-1:0] r_immData;
    logic [4:0]      r_rd;
    logic [6:0]      r_opcode;
    logic            r_illegal;

`ifdef ID_STAGE_BYPASS_EN
    logic [4:0]      r_rs1Idx;
    logic [4:0]      r_rs2Idx;
`endif

    logic [6:0]        w_opcode;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [4:0]        w_rd;
    immFmt_t           w_fmt;
    logic              w_opLegal;
    logic              w_illegal;
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]   w_imm;
    logic [XLEN-1:0]   w_rs1Data;
    logic [XLEN-1:0]   w_rs2Data;
    logic              w_wbWrite;
    logic              w_capture;

    // True when a 5-bit register index names an existing register.
    function automatic logic inRange(input logic [4:0] idx);
        return int'(idx) < NREGS;
    endfunction

    assign w_opcode = instruction[6:0];
    assign w_rd     = instruction[11:7];
    assign w_rs1    = instruction[19:15];
    assign w_rs2    = instruction[24:20];

    // The stage can take a new instruction whenever its slice is empty or
    // is being drained this very cycle. Flush vetoes the capture itself
    // but does not lower in_ready.
    assign in_ready  = !r_outValid || out_ready;
    assign w_capture = in_valid && in_ready && !flush;

    // Writes to x0 or to indices beyond the register file are dropped.
    assign w_wbWrite = wb_en && (wb_addr != 5'd0) && inRange(wb_addr);

    // Opcode classification: which opcodes are legal and which immediate
    // layout each one uses. R-type is legal but carries no immediate.
    always_comb begin
        w_fmt     = FMT_NONE;
        w_opLegal = 1'b1;
        case (w_opcode)
            7'b0110011: w_fmt = FMT_NONE;
            7'b0010011,
            7'b0000011,
            7'b1100111: w_fmt = FMT_I;
            7'b0100011: w_fmt = FMT_S;
            7'b1100011: w_fmt = FMT_B;
            7'b1101111: w_fmt = FMT_J;
            7'b0110111,
            7'b0010111: w_fmt = FMT_U;
            default:    w_opLegal = 1'b0;
        endcase
    end

    // Register-field checks apply to every format, so an encoding that
    // merely has unused high bits in a register slot is still rejected on
    // a 16-register configuration.
    assign w_illegal = !w_opLegal
                     || (instruction[1:0] != 2'b11)
                     || !inRange(w_rs1)
                     || !inRange(w_rs2)
                     || !inRange(w_rd);

    // Immediate assembly in 32 bits, then sign extension to XLEN.
    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            FMT_I:   w_imm32 = {{20{instruction[31]}}, instruction[31:20]};
            FMT_S:   w_imm32 = {{20{instruction[31]}}, instruction[31:25],
                                instruction[11:7]};
            FMT_B:   w_imm32 = {{19{instruction[31]}}, instruction[31],
                                instruction[7], instruction[30:25],
                                instruction[11:8], 1'b0};
            FMT_J:   w_imm32 = {{11{instruction[31]}}, instruction[31],
                                instruction[19:12], instruction[20],
                                instruction[30:21], 1'b0};
            FMT_U:   w_imm32 = {instruction[31:12], 12'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign w_imm = XLEN'(w_imm32);

    // Operand read. x0 and out-of-range indices read zero, and an illegal
    // instruction presents zero operands. With bypass enabled, a write
    // landing on the same register in this cycle is forwarded.
    always_comb begin
        w_rs1Data = '0;
        w_rs2Data = '0;
        if (!w_illegal) begin
            if (w_rs1 != 5'd0) begin
                w_rs1Data = r_regs[w_rs1[AW-1:0]];
            end
            if (w_rs2 != 5'd0) begin
                w_rs2Data = r_regs[w_rs2[AW-1:0]];
            end
`ifdef ID_STAGE_BYPASS_EN
            if (w_wbWrite && (wb_addr == w_rs1)) begin
                w_rs1Data = wb_data;
            end
            if (w_wbWrite && (wb_addr == w_rs2)) begin
                w_rs2Data = wb_data;
            end
`endif
        end
    end

    // Register file. Reset clears every entry; the writeback port is
    // ignored during reset but otherwise always commits, including in
    // flush and stall cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wbWrite) begin
            r_regs[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    // Output slice. Flush beats capture; a capture reloads the slice even
    // while the previous contents are being drained; otherwise a drain
    // empties it and a stall holds it (optionally refreshing operands).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_outValid <= 1'b0;
            r_rs1Data  <= '0;
            r_rs2Data  <= '0;
            r_immData  <= '0;
            r_rd       <= '0;
            r_opcode   <= '0;
            r_illegal  <= 1'b0;
`ifdef ID_STAGE_BYPASS_EN
            r_rs1Idx   <= '0;
            r_rs2Idx   <= '0;
`endif
        end else if (flush) begin
            r_outValid <= 1'b0;
        end else if (w_capture) begin
            r_outValid <= 1'b1;
            r_rs1Data  <= w_rs1Data;
            r_rs2Data  <= w_rs2Data;
            r_immData  <= w_imm;
            r_rd       <= w_rd;
            r_opcode   <= w_opcode;
            r_illegal  <= w_illegal;
`ifdef ID_STAGE_BYPASS_EN
            r_rs1Idx   <= w_rs1;
            r_rs2Idx   <= w_rs2;
`endif
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
`ifdef ID_STAGE_BYPASS_EN
        else if (r_outValid && !r_illegal && w_wbWrite) begin
            if (wb_addr == r_rs1Idx) begin
                r_rs1Data <= wb_data;
            end
            if (wb_addr == r_rs2Idx) begin
                r_rs2Data <= wb_data;
            end
        end
`endif
    end

    assign out_valid = r_outValid;
    assign rs1_data  = r_rs1Data;
    assign rs2_data  = r_rs2Data;
    assign imm_data  = r_immData;
    assign rd        = r_rd;
    assign opcode    = r_opcode;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// TbIdStagePipe (module tb_id_stage_pipe)
//
// Directed bench for id_stage_pipe. A default 32x32 instance carries most of
// the scenarios; a 16-register instance shares the same stimulus so that
// register-index range checking can be observed. Expected values for the
// bypass-sensitive cases follow ID_STAGE_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [31:0] instruction;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        flush;
    logic        outReady;

    logic        inReady;
    logic        outValid;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [31:0] immData;
    logic [4:0]  rdOut;
    logic [6:0]  opcodeOut;
    logic        illegalOut;

    logic        inReady16;
    logic        outValid16;
    logic [31:0] rs1Data16;
    logic [31:0] rs2Data16;
    logic [31:0] immData16;
    logic [4:0]  rdOut16;
    logic [6:0]  opcodeOut16;
    logic        illegalOut16;

    int checkCount;
    int errorCount;

    logic [31:0] expStall;
    logic [31:0] expCollide;

    id_stage_pipe #(.XLEN(32), .NREGS(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .instruction (instruction),
        .wb_en       (wbEn),
        .wb_addr     (wbAddr),
        .wb_data     (wbData),
        .flush       (flush),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .rs1_data    (rs1Data),
        .rs2_data    (rs2Data),
        .imm_data    (immData),
        .rd          (rdOut),
        .opcode      (opcodeOut),
        .illegal     (illegalOut)
    );

    id_stage_pipe #(.XLEN(32), .NREGS(16)) dut16 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (inValid),
        .in_ready    (inReady16),
        .instruction (instruction),
        .wb_en       (wbEn),
        .wb_addr     (wbAddr),
        .wb_data     (wbData),
        .flush       (flush),
        .out_valid   (outValid16),
        .out_ready   (outReady),
        .rs1_data    (rs1Data16),
        .rs2_data    (rs2Data16),
        .imm_data    (immData16),
        .rd          (rdOut16),
        .opcode      (opcodeOut16),
        .illegal     (illegalOut16)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // R-type encoding: add rd, rs1, rs2.
    function automatic logic [31:0] rType(input logic [4:0] rdI,
                                          input logic [4:0] rs1I,
                                          input logic [4:0] rs2I);
        return {7'b0, rs2I, rs1I, 3'b0, rdI, 7'b0110011};
    endfunction

    // I-type encoding: addi rd, rs1, imm.
    function automatic logic [31:0] iType(input logic [4:0]  rdI,
                                          input logic [4:0]  rs1I,
                                          input logic [11:0] immI);
        return {immI, rs1I, 3'b0, rdI, 7'b0010011};
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle just after the edge.
    task automatic applyStimulus(input logic        v,
                                 input logic [31:0] ins,
                                 input logic        we,
                                 input logic [4:0]  wa,
                                 input logic [31:0] wd,
                                 input logic        ordy,
                                 input logic        fl);
        inValid     = v;
        instruction = ins;
        wbEn        = we;
        wbAddr      = wa;
        wbData      = wd;
        outReady    = ordy;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
`ifdef ID_STAGE_BYPASS_EN
        expStall   = 32'h55;
        expCollide = 32'hA5;
`else
        expStall   = 32'h11;
        expCollide = 32'h0;
`endif
        rst = 1'b0;
        inValid = 1'b0; instruction = '0; wbEn = 1'b0; wbAddr = '0;
        wbData = '0; flush = 1'b0; outReady = 1'b1;
        #2;

        // Reset for two cycles with a capture and a writeback attempted;
        // both must be discarded.
        applyStimulus(1'b1, 32'hFFF00093, 1'b1, 5'd3, 32'h77, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hFFF00093, 1'b1, 5'd3, 32'h77, 1'b1, 1'b0);
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);
        checkOutput("rst_rs1", 64'(rs1Data), 64'd0);
        checkOutput("rst_imm", 64'(immData), 64'd0);
        checkOutput("rst_illegal", 64'(illegalOut), 64'd0);
        rst = 1'b1;
        inValid = 1'b0; wbEn = 1'b0;
        #1;
        checkOutput("rst_in_ready", 64'(inReady), 64'd1);

        // Every register reads zero after reset (x3 included despite the
        // writeback attempted during reset).
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, rType(5'd0, 5'(i), 5'(i)), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
            checkOutput($sformatf("rst_reg_x%0d", i), 64'(rs1Data | rs2Data), 64'd0);
        end

        // Idle cycle drains the slice, then back-to-back addi x1,x0,-1.
        applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("idle_out_valid", 64'(outValid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'hFFF00093, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
            checkOutput($sformatf("tp_valid_%0d", i), 64'(outValid), 64'd1);
            checkOutput($sformatf("tp_imm_%0d", i), 64'(immData), 64'hFFFFFFFF);
            checkOutput($sformatf("tp_in_ready_%0d", i), 64'(inReady), 64'd1);
        end
        checkOutput("tp_rd", 64'(rdOut), 64'd1);
        checkOutput("tp_opcode", 64'(opcodeOut), 64'h13);

        // Stall: x2=0x11, capture add x3,x2,x0, then hold for 3 cycles
        // while x2 is rewritten to 0x55 in the first held cycle.
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd2, 32'h11, 1'b1, 1'b0);
        applyStimulus(1'b1, rType(5'd3, 5'd2, 5'd0), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("stall_pre_rs1", 64'(rs1Data), 64'h11);
        applyStimulus(1'b1, iType(5'd4, 5'd2, 12'd5), 1'b1, 5'd2, 32'h55, 1'b0, 1'b0);
        checkOutput("stall_in_ready_1", 64'(inReady), 64'd0);
        applyStimulus(1'b1, iType(5'd4, 5'd2, 12'd5), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, iType(5'd4, 5'd2, 12'd5), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("stall_in_ready_3", 64'(inReady), 64'd0);
        checkOutput("stall_valid", 64'(outValid), 64'd1);
        checkOutput("stall_rd", 64'(rdOut), 64'd3);
        checkOutput("stall_opcode", 64'(opcodeOut), 64'h33);
        checkOutput("stall_imm", 64'(immData), 64'd0);
        checkOutput("stall_rs1", 64'(rs1Data), 64'(expStall));
        applyStimulus(1'b1, iType(5'd4, 5'd2, 12'd5), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("post_stall_rs1", 64'(rs1Data), 64'h55);
        checkOutput("post_stall_imm", 64'(immData), 64'd5);
        checkOutput("post_stall_rd", 64'(rdOut), 64'd4);

        // Collision: capture reading x5 while x5 is written.
        applyStimulus(1'b1, rType(5'd6, 5'd5, 5'd0), 1'b1, 5'd5, 32'hA5, 1'b1, 1'b0);
        checkOutput("collide_rs1", 64'(rs1Data), 64'(expCollide));
        applyStimulus(1'b1, rType(5'd6, 5'd5, 5'd0), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("collide_after_rs1", 64'(rs1Data), 64'hA5);
        applyStimulus(1'b1, rType(5'd7, 5'd0, 5'd0), 1'b1, 5'd0, 32'hFF, 1'b1, 1'b0);
        checkOutput("x0_collide", 64'(rs1Data), 64'd0);
        applyStimulus(1'b1, rType(5'd7, 5'd0, 5'd0), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("x0_read", 64'(rs1Data), 64'd0);

        // Illegality.
        applyStimulus(1'b1, rType(5'd1, 5'd5, 5'd20), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("n16_illegal", 64'(illegalOut16), 64'd1);
        checkOutput("n16_rs2", 64'(rs2Data16), 64'd0);
        checkOutput("n16_rs1", 64'(rs1Data16), 64'd0);
        checkOutput("n32_legal", 64'(illegalOut), 64'd0);
        checkOutput("n32_rs1", 64'(rs1Data), 64'hA5);
        applyStimulus(1'b1, 32'h0001007F, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("op7f_illegal", 64'(illegalOut), 64'd1);
        checkOutput("op7f_imm", 64'(immData), 64'd0);
        checkOutput("op7f_rs1", 64'(rs1Data), 64'd0);
        checkOutput("op7f_opcode", 64'(opcodeOut), 64'h7F);
        applyStimulus(1'b1, 32'h00000010, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("low_bits_illegal", 64'(illegalOut), 64'd1);

        // Immediate formats.
        applyStimulus(1'b1, 32'h123450B7, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("lui_imm", 64'(immData), 64'h12345000);
        checkOutput("lui_legal", 64'(illegalOut), 64'd0);
        applyStimulus(1'b1, 32'hFE002E23, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("s_imm", 64'(immData), 64'hFFFFFFFC);
        applyStimulus(1'b1, 32'h800006EF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("j_imm", 64'(immData), 64'hFFF00000);
        checkOutput("j_rd", 64'(rdOut), 64'd13);
        applyStimulus(1'b1, 32'h000000E3, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("b_imm", 64'(immData), 64'h00000800);

        // Flush beats capture; the concurrent writeback still lands.
        applyStimulus(1'b1, rType(5'd8, 5'd2, 5'd0), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("pre_flush_valid", 64'(outValid), 64'd1);
        applyStimulus(1'b1, rType(5'd11, 5'd0, 5'd0), 1'b1, 5'd9, 32'h99, 1'b1, 1'b1);
        checkOutput("flush_valid", 64'(outValid), 64'd0);
        checkOutput("flush_no_capture_rd", 64'(rdOut), 64'd8);
        applyStimulus(1'b1, rType(5'd10, 5'd9, 5'd0), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("flush_wb_rs1", 64'(rs1Data), 64'h99);
        checkOutput("flush_after_valid", 64'(outValid), 64'd1);
        checkOutput("flush_after_rd", 64'(rdOut), 64'd10);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
